// File: rtl/reg_file_param_if.sv
// reg_file_param_if: write, reserve and dual-read bus of reg_file_param
interface reg_file_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
);
  logic we;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic re_a;
  logic [AW-1:0] raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic pend_a;
  logic re_b;
  logic [AW-1:0] raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic pend_b;
  logic rsv;
  logic [AW-1:0] rsv_addr;
  logic [AW:0] pend_count;
  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, rsv, rsv_addr,
    input rdata_a, pend_a, rdata_b, pend_b, pend_count
  );
  modport slave (
    input we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, rsv, rsv_addr,
    output rdata_a, pend_a, rdata_b, pend_b, pend_count
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: register file with two registered read ports, write-first bypass and pending scoreboard; ZERO_REG_EN hardwires register 0
module reg_file_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input logic clk,
  input logic rst,
  reg_file_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_nxt;
  logic w_ok, r_ok, inc, dec, va, vb;
  logic [WIDTH-1:0] da, db;
`ifdef ZERO_REG_EN
  assign w_ok = bus.we && ({1'b0, bus.waddr} < DEP) && bus.waddr != '0;
  assign r_ok = bus.rsv && ({1'b0, bus.rsv_addr} < DEP) && bus.rsv_addr != '0;
`else
  assign w_ok = bus.we && ({1'b0, bus.waddr} < DEP);
  assign r_ok = bus.rsv && ({1'b0, bus.rsv_addr} < DEP);
`endif
  assign va = {1'b0, bus.raddr_a} < DEP;
  assign vb = {1'b0, bus.raddr_b} < DEP;
  assign da = !va ? '0 : (w_ok && bus.waddr == bus.raddr_a) ? bus.wdata : mem[bus.raddr_a];
  assign db = !vb ? '0 : (w_ok && bus.waddr == bus.raddr_b) ? bus.wdata : mem[bus.raddr_b];
  assign inc = r_ok && !pend[bus.rsv_addr];
  assign dec = w_ok && pend[bus.waddr] && !(r_ok && bus.rsv_addr == bus.waddr);
  // post-edge pending vector: a write releases, a reserve claims and wins a collision
  always_comb begin
    pend_nxt = pend;
    if (w_ok) pend_nxt[bus.waddr] = 1'b0;
    if (r_ok) pend_nxt[bus.rsv_addr] = 1'b1;
  end
  // storage, scoreboard and running pending count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
      bus.pend_count <= '0;
    end else begin
      if (w_ok) mem[bus.waddr] <= bus.wdata;
      pend <= pend_nxt;
      bus.pend_count <= bus.pend_count + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end
  // registered read ports, holding when not enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata_a <= '0;
      bus.pend_a <= 1'b0;
      bus.rdata_b <= '0;
      bus.pend_b <= 1'b0;
    end else begin
      if (bus.re_a) begin
        bus.rdata_a <= da;
        bus.pend_a <= va && pend_nxt[bus.raddr_a];
      end
      if (bus.re_b) begin
        bus.rdata_b <= db;
        bus.pend_b <= vb && pend_nxt[bus.raddr_b];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: random and directed checks of reg_file_param against an array-based model
module tb_reg_file_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 20;
  localparam int AW = $clog2(DEPTH);
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] m [DEPTH];
  bit p [DEPTH];
  logic [WIDTH-1:0] ea, eb;
  bit epa, epb;
  int ecnt;
  reg_file_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = '0;
      p[i] = 1'b0;
    end
    ea = '0;
    eb = '0;
    epa = 1'b0;
    epb = 1'b0;
    ecnt = 0;
  endtask
  task automatic idle();
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.re_a = 1'b0;
    bus.raddr_a = '0;
    bus.re_b = 1'b0;
    bus.raddr_b = '0;
    bus.rsv = 1'b0;
    bus.rsv_addr = '0;
  endtask
  function automatic bit ok_addr(int a);
    return a < DEPTH && !(ZR && a == 0);
  endfunction
  function automatic logic [WIDTH-1:0] rd(int a, bit w);
    if (a >= DEPTH) return '0;
    if (w && a == int'(bus.waddr)) return bus.wdata;
    return m[a];
  endfunction
  task automatic cyc();
    bit w, r;
    bit np [DEPTH];
    int wa, ra, aa, ab;
    wa = int'(bus.waddr);
    ra = int'(bus.rsv_addr);
    aa = int'(bus.raddr_a);
    ab = int'(bus.raddr_b);
    w = bus.we && ok_addr(wa);
    r = bus.rsv && ok_addr(ra);
    np = p;
    if (w) np[wa] = 1'b0;
    if (r) np[ra] = 1'b1;
    if (bus.re_a) begin
      ea = rd(aa, w);
      epa = (aa < DEPTH) ? np[aa] : 1'b0;
    end
    if (bus.re_b) begin
      eb = rd(ab, w);
      epb = (ab < DEPTH) ? np[ab] : 1'b0;
    end
    if (w) m[wa] = bus.wdata;
    p = np;
    ecnt = 0;
    for (int i = 0; i < DEPTH; i++) ecnt += int'(p[i]);
    @(posedge clk);
    #1;
    check("rdata_a", 64'(bus.rdata_a), 64'(ea));
    check("pend_a", 64'(bus.pend_a), 64'(epa));
    check("rdata_b", 64'(bus.rdata_b), 64'(eb));
    check("pend_b", 64'(bus.pend_b), 64'(epb));
    check("pend_count", 64'(bus.pend_count), 64'(ecnt));
  endtask
  task automatic mid_reset();
    idle();
    bus.we = 1'b1;
    bus.waddr = AW'(9);
    bus.wdata = 32'hA5A5A5A5;
    bus.rsv = 1'b1;
    bus.rsv_addr = AW'(10);
    #2;
    rst = 1'b0;
    #1;
    check("rst_rdata_a", 64'(bus.rdata_a), 64'(0));
    check("rst_rdata_b", 64'(bus.rdata_b), 64'(0));
    check("rst_pend_a", 64'(bus.pend_a), 64'(0));
    check("rst_pend_b", 64'(bus.pend_b), 64'(0));
    check("rst_count", 64'(bus.pend_count), 64'(0));
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      bus.we = 1'b1;
      bus.waddr = AW'(i);
      bus.wdata = $urandom;
      bus.rsv = i[0];
      bus.rsv_addr = AW'(DEPTH - 1 - i);
      bus.re_a = 1'b1;
      bus.raddr_a = AW'(i);
      cyc();
    end
    mid_reset();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      bus.re_a = 1'b1;
      bus.raddr_a = AW'(i);
      bus.re_b = 1'b1;
      bus.raddr_b = AW'(DEPTH - 1 - i);
      cyc();
    end
    idle();
    bus.we = 1'b1;
    bus.waddr = AW'(5);
    bus.wdata = 32'hDEADBEEF;
    cyc();
    idle();
    bus.re_a = 1'b1;
    bus.raddr_a = AW'(5);
    cyc();
    check("wr_lat", 64'(bus.rdata_a), 64'h0DEADBEEF);
    idle();
    bus.we = 1'b1;
    bus.waddr = AW'(5);
    bus.wdata = 32'h01020304;
    bus.raddr_a = AW'(5);
    cyc();
    check("hold", 64'(bus.rdata_a), 64'h0DEADBEEF);
    idle();
    bus.we = 1'b1;
    bus.waddr = AW'(7);
    bus.wdata = 32'h12345678;
    bus.re_a = 1'b1;
    bus.raddr_a = AW'(7);
    bus.re_b = 1'b1;
    bus.raddr_b = AW'(7);
    cyc();
    check("bypass_a", 64'(bus.rdata_a), 64'h12345678);
    check("bypass_b", 64'(bus.rdata_b), 64'h12345678);
    check("bypass_pend", 64'(bus.pend_a), 64'(0));
    idle();
    bus.rsv = 1'b1;
    bus.rsv_addr = AW'(3);
    cyc();
    check("sb_rsv_cnt", 64'(bus.pend_count), 64'(1));
    idle();
    bus.re_a = 1'b1;
    bus.raddr_a = AW'(3);
    cyc();
    check("sb_rd_pend", 64'(bus.pend_a), 64'(1));
    bus.rsv = 1'b1;
    bus.rsv_addr = AW'(3);
    bus.we = 1'b1;
    bus.waddr = AW'(3);
    bus.wdata = 32'h33;
    cyc();
    check("sb_both_pend", 64'(bus.pend_a), 64'(1));
    check("sb_both_cnt", 64'(bus.pend_count), 64'(1));
    bus.rsv = 1'b0;
    cyc();
    check("sb_wr_pend", 64'(bus.pend_a), 64'(0));
    check("sb_wr_cnt", 64'(bus.pend_count), 64'(0));
    idle();
    bus.rsv = 1'b1;
    bus.rsv_addr = AW'(1);
    cyc();
    bus.rsv_addr = AW'(2);
    cyc();
    check("cc_pre", 64'(bus.pend_count), 64'(2));
    bus.rsv_addr = AW'(4);
    bus.we = 1'b1;
    bus.waddr = AW'(1);
    cyc();
    check("cc_net", 64'(bus.pend_count), 64'(2));
    idle();
    bus.we = 1'b1;
    bus.waddr = AW'(2);
    cyc();
    bus.waddr = AW'(4);
    cyc();
    idle();
    bus.we = 1'b1;
    bus.waddr = '0;
    bus.wdata = 32'hFFFFFFFF;
    bus.re_a = 1'b1;
    bus.raddr_a = '0;
    cyc();
    check("zr_data", 64'(bus.rdata_a), ZR ? 64'(0) : 64'hFFFFFFFF);
    idle();
    bus.rsv = 1'b1;
    bus.rsv_addr = '0;
    cyc();
    idle();
    bus.re_a = 1'b1;
    bus.raddr_a = '0;
    cyc();
    check("zr_pend", 64'(bus.pend_a), ZR ? 64'(0) : 64'(1));
    check("zr_cnt", 64'(bus.pend_count), ZR ? 64'(0) : 64'(1));
    idle();
    bus.we = 1'b1;
    bus.waddr = '0;
    cyc();
    idle();
    bus.we = 1'b1;
    bus.waddr = AW'(25);
    bus.wdata = 32'hCAFEF00D;
    bus.rsv = 1'b1;
    bus.rsv_addr = AW'(25);
    bus.re_a = 1'b1;
    bus.raddr_a = AW'(25);
    bus.re_b = 1'b1;
    bus.raddr_b = AW'(DEPTH - 1);
    cyc();
    check("oor_data", 64'(bus.rdata_a), 64'(0));
    check("oor_pend", 64'(bus.pend_a), 64'(0));
    check("oor_cnt", 64'(bus.pend_count), 64'(0));
    for (int n = 0; n < 3000; n++) begin
      int sh;
      if (n % 700 == 699) mid_reset();
      sh = $urandom_range(0, 31);
      bus.we = 1'($urandom);
      bus.waddr = AW'(($urandom_range(0, 2) == 0) ? sh : $urandom_range(0, 31));
      bus.wdata = $urandom;
      bus.rsv = 1'($urandom);
      bus.rsv_addr = AW'(($urandom_range(0, 2) == 0) ? sh : $urandom_range(0, 31));
      bus.re_a = 1'($urandom_range(0, 3) != 0);
      bus.raddr_a = AW'(($urandom_range(0, 2) == 0) ? sh : $urandom_range(0, 31));
      bus.re_b = 1'($urandom_range(0, 3) != 0);
      bus.raddr_b = AW'(($urandom_range(0, 2) == 0) ? sh : $urandom_range(0, 31));
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
